// File: rtl/wbvga_modectl_pkg.sv
// Shared constants for the VGA mode controller.
// Register addresses, CTRL bit positions, 640x480 defaults, FSM states.
package wbvga_modectl_pkg;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_BASE   = 3'd1;
    localparam logic [2:0] A_H0     = 3'd2;
    localparam logic [2:0] A_H1     = 3'd3;
    localparam logic [2:0] A_V0     = 3'd4;
    localparam logic [2:0] A_V1     = 3'd5;
    localparam logic [2:0] A_STRIDE = 3'd6;
    localparam logic [2:0] A_STATUS = 3'd7;

    localparam int C_EN     = 0;
    localparam int C_TEST   = 1;
    localparam int C_COMMIT = 2;
    localparam int C_ERR    = 29;
    localparam int C_ACT    = 30;
    localparam int C_PEND   = 31;

    localparam int DEF_HW     = 640;
    localparam int DEF_HP     = 656;
    localparam int DEF_HS     = 752;
    localparam int DEF_HR     = 800;
    localparam int DEF_VH     = 480;
    localparam int DEF_VP     = 490;
    localparam int DEF_VS     = 492;
    localparam int DEF_VR     = 525;
    localparam int DEF_STRIDE = 640;

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN,
        S_WAIT,
        S_SETTLE
    } state_t;

    // Expand Wishbone byte selects into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wbvga_modectl_check.sv
// Ordering validator for one timing set: size < porch < synch < raw.
// Ports: i_size/i_porch/i_synch/i_raw (W bits), o_ok high when strictly increasing.
module vga_mode_check
    import wbvga_modectl_pkg::*;
#(
    parameter int W = 13
) (
    input  logic [W-1:0] i_size,
    input  logic [W-1:0] i_porch,
    input  logic [W-1:0] i_synch,
    input  logic [W-1:0] i_raw,
    output logic         o_ok
);

    assign o_ok = (i_size < i_porch) && (i_porch < i_synch) && (i_synch < i_raw);

endmodule

// File: rtl/wbvga_modectl.sv
// Wishbone mode controller: shadows base/stride/timing, validates, applies at frame edges.
// Ports: Wishbone slave (i_wb_*, o_wb_*), i_frame pulse in, active mode outputs, o_interrupt.
module wbvga_modectl
    import wbvga_modectl_pkg::*;
#(
    parameter int AW     = 24,
    parameter int FW     = 13,
    parameter int LW     = 11,
    parameter int SETTLE = 16,
    parameter int TW     = 24
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [2:0]    i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    input  logic          i_frame,
    output logic          o_en,
    output logic          o_test,
    output logic [AW-1:0] o_base,
    output logic [FW:0]   o_line_words,
    output logic [FW-1:0] o_hm_width,
    output logic [FW-1:0] o_hm_porch,
    output logic [FW-1:0] o_hm_synch,
    output logic [FW-1:0] o_hm_raw,
    output logic [LW-1:0] o_vm_height,
    output logic [LW-1:0] o_vm_porch,
    output logic [LW-1:0] o_vm_synch,
    output logic [LW-1:0] o_vm_raw,
    output logic          o_interrupt
);

    state_t        r_state, w_state_nx;
    logic [TW-1:0] r_cnt;

    logic [AW-1:0] r_sh_base;
    logic [FW:0]   r_sh_stride;
    logic [FW-1:0] r_sh_hw, r_sh_hp, r_sh_hs, r_sh_hr;
    logic [LW-1:0] r_sh_vh, r_sh_vp, r_sh_vs, r_sh_vr;
    logic          r_sh_en, r_sh_test;

    logic          r_err, r_pend, r_tchg, r_bchg;
    logic [15:0]   r_fcnt;

    logic [31:0]   w_m, w_rdata;
    logic          w_wr, w_ctrl_wr, w_en_nx, w_test_nx;
    logic          w_commit, w_h_ok, w_v_ok, w_cok, w_cbad;
    logic          w_tset, w_bset, w_trig;
    logic          w_apply_all, w_apply_base, w_irq_set;
    logic          w_unused;

    assign o_wb_stall = 1'b0;
    assign o_en       = (r_state == S_RUN) || (r_state == S_WAIT);

    assign w_m       = sel_mask(i_wb_sel);
    assign w_wr      = i_wb_cyc && i_wb_stb && i_wb_we;
    assign w_ctrl_wr = w_wr && (i_wb_addr == A_CTRL) && i_wb_sel[0];
    assign w_en_nx   = w_ctrl_wr ? i_wb_data[C_EN] : r_sh_en;
    assign w_test_nx = w_ctrl_wr ? i_wb_data[C_TEST] : r_sh_test;
    assign w_commit  = w_ctrl_wr && i_wb_data[C_COMMIT];
    assign w_cok     = w_commit && w_h_ok && w_v_ok;
    assign w_cbad    = w_commit && !(w_h_ok && w_v_ok);

    // Rewriting CTRL with unchanged enable/test must not turn a
    // page flip into a full timing change.
    assign w_tset = (w_wr && (i_wb_addr >= A_H0) && (i_wb_addr <= A_STRIDE))
                 || (w_ctrl_wr && ((w_en_nx != r_sh_en) || (w_test_nx != r_sh_test)));
    assign w_bset = w_wr && (i_wb_addr == A_BASE);

    // A frame coinciding with a (re)commit is not taken as the apply point.
    assign w_trig = (&r_cnt) || (i_frame && !w_commit);

    assign w_unused = &{1'b0, w_m[31:29], i_wb_data[31:29]};

    vga_mode_check #(.W(FW)) u_hchk (
        .i_size  (r_sh_hw),
        .i_porch (r_sh_hp),
        .i_synch (r_sh_hs),
        .i_raw   (r_sh_hr),
        .o_ok    (w_h_ok)
    );

    vga_mode_check #(.W(LW)) u_vchk (
        .i_size  (r_sh_vh),
        .i_porch (r_sh_vp),
        .i_synch (r_sh_vs),
        .i_raw   (r_sh_vr),
        .o_ok    (w_v_ok)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_apply_all  = 1'b0;
        w_apply_base = 1'b0;
        w_irq_set    = 1'b0;
        unique case (r_state)
            S_OFF: begin
                if (w_cok) begin
                    w_apply_all = 1'b1;
                    if (w_en_nx) w_state_nx = S_SETTLE;
                    else         w_irq_set  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_cok) w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (w_cbad) begin
                    w_state_nx = S_RUN;
                end else if (w_trig) begin
                    if (r_tchg) begin
                        w_apply_all = 1'b1;
                        if (r_sh_en) begin
                            w_state_nx = S_SETTLE;
                        end else begin
                            w_state_nx = S_OFF;
                            w_irq_set  = 1'b1;
                        end
                    end else begin
                        w_apply_base = 1'b1;
                        w_state_nx   = S_RUN;
                        w_irq_set    = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt == TW'(SETTLE - 1)) begin
                    w_state_nx = S_RUN;
                    w_irq_set  = 1'b1;
                end
            end
            default: w_state_nx = S_OFF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            // Counts idle cycles in SETTLE and the frame timeout in WAIT.
            if ((w_state_nx != r_state) || !r_state[1])
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_wb_addr)
            A_CTRL: begin
                w_rdata[C_EN]   = r_sh_en;
                w_rdata[C_TEST] = r_sh_test;
                w_rdata[C_ERR]  = r_err;
                w_rdata[C_ACT]  = o_en;
                w_rdata[C_PEND] = r_pend;
            end
            A_BASE:   w_rdata[AW-1:0] = r_sh_base;
            A_H0: begin
                w_rdata[FW-1:0]  = r_sh_hw;
                w_rdata[FW+15:16] = r_sh_hp;
            end
            A_H1: begin
                w_rdata[FW-1:0]  = r_sh_hs;
                w_rdata[FW+15:16] = r_sh_hr;
            end
            A_V0: begin
                w_rdata[LW-1:0]  = r_sh_vh;
                w_rdata[LW+15:16] = r_sh_vp;
            end
            A_V1: begin
                w_rdata[LW-1:0]  = r_sh_vs;
                w_rdata[LW+15:16] = r_sh_vr;
            end
            A_STRIDE: w_rdata[FW:0] = r_sh_stride;
            default: begin
                w_rdata[15:0] = r_fcnt;
                w_rdata[16]   = o_interrupt;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_cyc && i_wb_stb;
            if (i_wb_cyc && i_wb_stb)
                o_wb_data <= w_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_base   <= '0;
            r_sh_stride <= (FW+1)'(DEF_STRIDE);
            r_sh_hw     <= FW'(DEF_HW);
            r_sh_hp     <= FW'(DEF_HP);
            r_sh_hs     <= FW'(DEF_HS);
            r_sh_hr     <= FW'(DEF_HR);
            r_sh_vh     <= LW'(DEF_VH);
            r_sh_vp     <= LW'(DEF_VP);
            r_sh_vs     <= LW'(DEF_VS);
            r_sh_vr     <= LW'(DEF_VR);
            r_sh_en     <= 1'b0;
            r_sh_test   <= 1'b0;
        end else begin
            r_sh_en   <= w_en_nx;
            r_sh_test <= w_test_nx;
            if (w_wr) begin
                case (i_wb_addr)
                    A_BASE: r_sh_base <= (r_sh_base & ~w_m[AW-1:0])
                                       | (i_wb_data[AW-1:0] & w_m[AW-1:0]);
                    A_H0: begin
                        r_sh_hw <= (r_sh_hw & ~w_m[FW-1:0])
                                 | (i_wb_data[FW-1:0] & w_m[FW-1:0]);
                        r_sh_hp <= (r_sh_hp & ~w_m[FW+15:16])
                                 | (i_wb_data[FW+15:16] & w_m[FW+15:16]);
                    end
                    A_H1: begin
                        r_sh_hs <= (r_sh_hs & ~w_m[FW-1:0])
                                 | (i_wb_data[FW-1:0] & w_m[FW-1:0]);
                        r_sh_hr <= (r_sh_hr & ~w_m[FW+15:16])
                                 | (i_wb_data[FW+15:16] & w_m[FW+15:16]);
                    end
                    A_V0: begin
                        r_sh_vh <= (r_sh_vh & ~w_m[LW-1:0])
                                 | (i_wb_data[LW-1:0] & w_m[LW-1:0]);
                        r_sh_vp <= (r_sh_vp & ~w_m[LW+15:16])
                                 | (i_wb_data[LW+15:16] & w_m[LW+15:16]);
                    end
                    A_V1: begin
                        r_sh_vs <= (r_sh_vs & ~w_m[LW-1:0])
                                 | (i_wb_data[LW-1:0] & w_m[LW-1:0]);
                        r_sh_vr <= (r_sh_vr & ~w_m[LW+15:16])
                                 | (i_wb_data[LW+15:16] & w_m[LW+15:16]);
                    end
                    A_STRIDE: r_sh_stride <= (r_sh_stride & ~w_m[FW:0])
                                           | (i_wb_data[FW:0] & w_m[FW:0]);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err       <= 1'b0;
            r_pend      <= 1'b0;
            r_tchg      <= 1'b0;
            r_bchg      <= 1'b0;
            r_fcnt      <= '0;
            o_interrupt <= 1'b0;
        end else begin
            if (i_frame)
                r_fcnt <= r_fcnt + 16'd1;
            if (w_cbad) begin
                r_err  <= 1'b1;
                r_pend <= 1'b0;
                r_tchg <= 1'b0;
                r_bchg <= 1'b0;
            end else begin
                if (w_cok) begin
                    r_err  <= 1'b0;
                    r_pend <= 1'b1;
                end
                if (w_tset) r_tchg <= 1'b1;
                if (w_bset) r_bchg <= 1'b1;
                // An apply in the commit cycle (from OFF) wins over the set.
                if (w_apply_all || w_apply_base) begin
                    r_pend <= 1'b0;
                    r_tchg <= 1'b0;
                    r_bchg <= 1'b0;
                end
            end
            if (w_irq_set)
                o_interrupt <= 1'b1;
            else if (w_wr && (i_wb_addr == A_STATUS))
                o_interrupt <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_test       <= 1'b0;
            o_base       <= '0;
            o_line_words <= (FW+1)'(DEF_STRIDE);
            o_hm_width   <= FW'(DEF_HW);
            o_hm_porch   <= FW'(DEF_HP);
            o_hm_synch   <= FW'(DEF_HS);
            o_hm_raw     <= FW'(DEF_HR);
            o_vm_height  <= LW'(DEF_VH);
            o_vm_porch   <= LW'(DEF_VP);
            o_vm_synch   <= LW'(DEF_VS);
            o_vm_raw     <= LW'(DEF_VR);
        end else if (w_apply_all) begin
            o_test       <= w_test_nx;
            o_base       <= r_sh_base;
            o_line_words <= r_sh_stride;
            o_hm_width   <= r_sh_hw;
            o_hm_porch   <= r_sh_hp;
            o_hm_synch   <= r_sh_hs;
            o_hm_raw     <= r_sh_hr;
            o_vm_height  <= r_sh_vh;
            o_vm_porch   <= r_sh_vp;
            o_vm_synch   <= r_sh_vs;
            o_vm_raw     <= r_sh_vr;
        end else if (w_apply_base && r_bchg) begin
            o_base <= r_sh_base;
        end
    end

endmodule

// File: tb/tb_wbvga_modectl.sv
// Testbench for wbvga_modectl: directed bus/frame stimulus, read-data scoreboard.
// Expected read data is queued at issue and compared by an ack-driven monitor.
module tb_wbvga_modectl;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        frame;

    logic        stall, ack;
    logic [31:0] rdat;
    logic        en, test, irq;
    logic [23:0] base;
    logic [13:0] lw;
    logic [12:0] hw, hp, hs, hr;
    logic [10:0] vh, vp, vs, vr;

    int checks   = 0;
    int failures = 0;
    int drops    = 0;
    logic watch  = 1'b0;
    int n;

    typedef struct {
        logic        rd;
        logic [2:0]  a;
        logic [31:0] x;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    wbvga_modectl #(.TW(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_data    (wdat),
        .i_wb_sel     (sel),
        .o_wb_stall   (stall),
        .o_wb_ack     (ack),
        .o_wb_data    (rdat),
        .i_frame      (frame),
        .o_en         (en),
        .o_test       (test),
        .o_base       (base),
        .o_line_words (lw),
        .o_hm_width   (hw),
        .o_hm_porch   (hp),
        .o_hm_synch   (hs),
        .o_hm_raw     (hr),
        .o_vm_height  (vh),
        .o_vm_porch   (vp),
        .o_vm_synch   (vs),
        .o_vm_raw     (vr),
        .o_interrupt  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch && !en) drops++;
        if (ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_ack got ack with empty queue");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.rd) begin
                    checks++;
                    if (rdat !== mon_e.x) begin
                        failures++;
                        $display("FAIL rd_addr%0d got %h want %h", mon_e.a, rdat, mon_e.x);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] x);
        checks++;
        if (act !== x) begin
            failures++;
            $display("FAIL %s got %h want %h", nm, act, x);
        end
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [31:0] x, input logic [3:0] s, input logic f);
        exp_t e;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s; frame = f;
        e.rd = !w;
        e.a  = a;
        e.x  = x;
        sb.push_back(e);
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; frame = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 32'h0, 4'hF, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] x);
        bus(1'b0, a, 32'h0, x, 4'hF, 1'b0);
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1 frame = 1;
        @(posedge clk); #1 frame = 0;
    endtask

    // Counts negedge samples until o_en equals lvl, bounded by lim.
    task automatic wait_en(input logic lvl, input int lim, output int cnt);
        cnt = 0;
        while (cnt < lim) begin
            @(negedge clk);
            if (en == lvl) break;
            cnt++;
        end
    endtask

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; addr = 0; wdat = 0; sel = 0; frame = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        chk("rst_en", 32'(en), 32'd0);
        chk("rst_hraw", 32'(hr), 32'd800);
        chk("rst_vraw", 32'(vr), 32'd525);
        chk("rst_base", 32'(base), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_stride", 32'(lw), 32'd640);
        rd(3'd0, 32'h0);
        rd(3'd2, 32'h0290_0280);
        rd(3'd7, 32'h0);

        wr(3'd1, 32'h1000);
        wr(3'd0, 32'h5);
        wait_en(1'b1, 100, n);
        chk("off_settle_len", 32'(n), 32'd16);
        chk("off_base", 32'(base), 32'h1000);
        chk("off_irq", 32'(irq), 32'd1);
        rd(3'd0, 32'h4000_0001);
        wr(3'd7, 32'h0);
        chk("irq_clear", 32'(irq), 32'd0);

        watch = 1;
        wr(3'd1, 32'h2000);
        wr(3'd0, 32'h5);
        rd(3'd0, 32'hC000_0001);
        chk("flip_before", 32'(base), 32'h1000);
        pulse_frame();
        chk("flip_base", 32'(base), 32'h2000);
        chk("flip_irq", 32'(irq), 32'd1);
        watch = 0;
        chk("flip_no_drop", 32'(drops), 32'd0);
        rd(3'd0, 32'h4000_0001);
        rd(3'd7, 32'h0001_0001);
        wr(3'd7, 32'h0);

        wr(3'd2, 32'h0348_0320);
        wr(3'd3, 32'h0420_03C8);
        wr(3'd0, 32'h5);
        chk("tim_hold", 32'(hw), 32'd640);
        pulse_frame();
        chk("tim_en_drop", 32'(en), 32'd0);
        chk("tim_hw", 32'(hw), 32'd800);
        chk("tim_hp", 32'(hp), 32'd840);
        chk("tim_hs", 32'(hs), 32'd968);
        chk("tim_hr", 32'(hr), 32'd1056);
        wait_en(1'b1, 100, n);
        chk("tim_settle_len", 32'(n), 32'd16);
        chk("tim_irq", 32'(irq), 32'd1);
        rd(3'd3, 32'h0420_03C8);
        wr(3'd7, 32'h0);

        bus(1'b1, 3'd1, 32'h00AB_0000, 32'h0, 4'b0100, 1'b0);
        rd(3'd1, 32'h00AB_2000);
        chk("sel_active_base", 32'(base), 32'h2000);

        wr(3'd2, 32'h0258_0280);
        wr(3'd0, 32'h5);
        rd(3'd0, 32'h6000_0001);
        chk("err_hw", 32'(hw), 32'd800);
        chk("err_en", 32'(en), 32'd1);
        rd(3'd2, 32'h0258_0280);

        wr(3'd2, 32'h0348_0320);
        wr(3'd4, 32'h01EA_0190);
        wr(3'd0, 32'h5);
        wait_en(1'b0, 400, n);
        chk("tmo_wait_len", 32'(n), 32'd256);
        chk("tmo_vh", 32'(vh), 32'd400);
        chk("tmo_base", 32'(base), 32'h00AB_2000);
        wait_en(1'b1, 40, n);
        chk("tmo_settle_rest", 32'(n), 32'd15);
        chk("tmo_irq", 32'(irq), 32'd1);
        rd(3'd0, 32'h4000_0001);
        wr(3'd7, 32'h0);

        wr(3'd4, 32'h01EA_01E0);
        bus(1'b1, 3'd0, 32'h5, 32'h0, 4'hF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("same_frame_en", 32'(en), 32'd1);
        chk("same_frame_vh", 32'(vh), 32'd400);
        pulse_frame();
        chk("second_frame_en", 32'(en), 32'd0);
        chk("second_frame_vh", 32'(vh), 32'd480);
        wait_en(1'b1, 40, n);
        chk("second_settle_len", 32'(n), 32'd16);
        rd(3'd7, 32'h0001_0004);

        wr(3'd7, 32'h0);
        wr(3'd0, 32'h7);
        pulse_frame();
        chk("test_en", 32'(en), 32'd0);
        chk("test_out", 32'(test), 32'd1);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_base", 32'(base), 32'd0);
        chk("mid_rst_hw", 32'(hw), 32'd640);
        chk("mid_rst_vh", 32'(vh), 32'd480);
        chk("mid_rst_test", 32'(test), 32'd0);
        chk("mid_rst_stride", 32'(lw), 32'd640);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_stays_off", 32'(en), 32'd0);
        rd(3'd0, 32'h0);
        rd(3'd7, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
